ram_access_controller: RTL

Initiator-side controller that drives a single-port synchronous RAM (data/addr/we in, q out, one-cycle registered read).
- Accepts read/write requests from a client over a valid/ready handshake and returns read data over a valid/ready response channel.
- Optionally clears the whole RAM to zero after reset.
- Sits between client logic and the single_port_ram instance; it is the only master of the RAM port.

---
 rtl/ram_access_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/ram_access_controller.sv
// Initiator-side controller for a single-port synchronous RAM with a one-cycle registered read.
// It serves client reads and writes, and can zero-fill the whole RAM after reset.
module ram_access_controller #(
    parameter int addr_width     = 6,
    parameter int data_width     = 8,
    parameter int depth          = 64,
    parameter bit clear_on_reset = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [addr_width-1:0] req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    output logic [data_width-1:0] ram_data,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [data_width-1:0] ram_q
);

    localparam logic [1:0] INIT    = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] RSP     = 2'd3;

    localparam logic [addr_width:0]   depth_w   = (addr_width+1)'(depth);
    localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);

    logic [1:0]            state;
    logic [addr_width-1:0] cnt;
    logic [addr_width-1:0] addr_q;
    logic                  oor_q;
    logic                  req_in_range;

    assign req_in_range = ({1'b0, req_addr} < depth_w);
    assign req_ready    = (state == IDLE);

    // In IDLE the request address goes straight to the RAM, so read data
    // is already on ram_q during RD_WAIT.
    always_comb begin
        ram_we   = 1'b0;
        ram_data = '0;
        ram_addr = addr_q;
        case (state)
            INIT: begin
                ram_we   = 1'b1;
                ram_addr = cnt;
            end
            IDLE: begin
                ram_addr = req_addr;
                ram_data = req_wdata;
                ram_we   = req_valid & req_we & req_in_range;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= clear_on_reset ? INIT : IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            oor_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            init_done <= !clear_on_reset;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == last_addr) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid && !req_we) begin
                        addr_q <= req_addr;
                        oor_q  <= !req_in_range;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rsp_rdata <= oor_q ? '0 : ram_q;
                    rsp_err   <= oor_q;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
